// File: rtl/i2c_slave_apb.sv
// APB-attached I2C target: oversampled SCL/SDA, 7-bit address match, byte RX/TX
// through memory-mapped registers, open-drain SDA drive.
module i2c_slave_apb #(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [6:0] RST_OWN_ADDR = 7'h50
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic [3:0]  paddr,
    input  logic        pwrite,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    input  logic        SCL,
    inout  wire         SDA
);
    localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, IGNORE
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shreg_reg, shreg_next;
    logic       sda_oe_reg, sda_oe_next;
    logic       ack_phase_reg, ack_phase_next;
    logic       ack_en_reg, ack_en_next;
    logic       byte_done_reg, byte_done_next;

    logic [NSYNC-1:0] scl_sync_reg, sda_sync_reg;
    logic       scl_d_reg, sda_d_reg;
    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    logic       en_reg, rx_valid_reg, overrun_reg, rw_reg, nack_reg, underrun_reg, tx_valid_reg;
    logic [6:0] own_addr_reg;
    logic [7:0] rxdata_reg, txdata_reg;
    logic       rw_load, rx_commit, rx_overrun_set, tx_load, nack_set;
    logic       wr_en, rd_en, busy;
    logic [1:0] reg_sel;
    logic [31:0] rd_mux;

    assign SDA = sda_oe_reg ? 1'b0 : 1'bz;

    // Bus idles high, so the synchronizers reset to 1 to avoid a false edge after reset.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_d_reg    <= 1'b1;
            sda_d_reg    <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[NSYNC-2:0], SCL};
            sda_sync_reg <= {sda_sync_reg[NSYNC-2:0], SDA};
            scl_d_reg    <= scl_s;
            sda_d_reg    <= sda_s;
        end
    end

    assign scl_s     = scl_sync_reg[NSYNC-1];
    assign sda_s     = sda_sync_reg[NSYNC-1];
    assign scl_rise  = scl_s & ~scl_d_reg;
    assign scl_fall  = ~scl_s & scl_d_reg;
    assign start_det = scl_s & scl_d_reg & sda_d_reg & ~sda_s;
    assign stop_det  = scl_s & scl_d_reg & ~sda_d_reg & sda_s;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= 3'd0;
            shreg_reg     <= 8'd0;
            sda_oe_reg    <= 1'b0;
            ack_phase_reg <= 1'b0;
            ack_en_reg    <= 1'b0;
            byte_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shreg_reg     <= shreg_next;
            sda_oe_reg    <= sda_oe_next;
            ack_phase_reg <= ack_phase_next;
            ack_en_reg    <= ack_en_next;
            byte_done_reg <= byte_done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shreg_next     = shreg_reg;
        sda_oe_next    = sda_oe_reg;
        ack_phase_next = ack_phase_reg;
        ack_en_next    = ack_en_reg;
        byte_done_next = byte_done_reg;
        rw_load        = 1'b0;
        rx_commit      = 1'b0;
        rx_overrun_set = 1'b0;
        tx_load        = 1'b0;
        nack_set       = 1'b0;
        if (!en_reg) begin
            state_next  = IDLE;
            sda_oe_next = 1'b0;
        end else if (stop_det) begin
            state_next  = IDLE;
            sda_oe_next = 1'b0;
        end else if (start_det) begin
            state_next     = ADDR;
            bit_cnt_next   = 3'd0;
            sda_oe_next    = 1'b0;
            ack_phase_next = 1'b0;
            byte_done_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE, IGNORE: sda_oe_next = 1'b0;
                ADDR: if (scl_rise) begin
                    shreg_next   = {shreg_reg[6:0], sda_s};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        if (shreg_reg[6:0] == own_addr_reg) begin
                            state_next     = ADDR_ACK;
                            rw_load        = 1'b1;
                            ack_phase_next = 1'b0;
                        end else begin
                            state_next = IGNORE;
                        end
                    end
                end
                // First fall starts the ACK; second fall ends it and, for reads,
                // presents the first data bit on the same edge.
                ADDR_ACK: if (scl_fall) begin
                    if (!ack_phase_reg) begin
                        sda_oe_next    = 1'b1;
                        ack_phase_next = 1'b1;
                    end else begin
                        ack_phase_next = 1'b0;
                        bit_cnt_next   = 3'd0;
                        byte_done_next = 1'b0;
                        if (rw_reg) begin
                            state_next  = TX_BYTE;
                            tx_load     = 1'b1;
                            sda_oe_next = ~txdata_reg[7];
                            shreg_next  = {txdata_reg[6:0], 1'b0};
                        end else begin
                            state_next  = RX_BYTE;
                            sda_oe_next = 1'b0;
                        end
                    end
                end
                RX_BYTE: if (scl_rise) begin
                    shreg_next   = {shreg_reg[6:0], sda_s};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next     = RX_ACK;
                        ack_phase_next = 1'b0;
                        ack_en_next    = ~rx_valid_reg;
                        rx_commit      = ~rx_valid_reg;
                        rx_overrun_set = rx_valid_reg;
                    end
                end
                RX_ACK: if (scl_fall) begin
                    if (!ack_phase_reg) begin
                        sda_oe_next    = ack_en_reg;
                        ack_phase_next = 1'b1;
                    end else begin
                        sda_oe_next    = 1'b0;
                        ack_phase_next = 1'b0;
                        bit_cnt_next   = 3'd0;
                        state_next     = RX_BYTE;
                    end
                end
                TX_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7)
                            byte_done_next = 1'b1;
                    end else if (scl_fall) begin
                        if (byte_done_reg) begin
                            sda_oe_next    = 1'b0;
                            byte_done_next = 1'b0;
                            state_next     = TX_ACK;
                        end else begin
                            sda_oe_next = ~shreg_reg[7];
                            shreg_next  = {shreg_reg[6:0], 1'b0};
                        end
                    end
                end
                TX_ACK: begin
                    sda_oe_next = 1'b0;
                    if (scl_rise) begin
                        if (!sda_s) begin
                            state_next     = TX_BYTE;
                            tx_load        = 1'b1;
                            shreg_next     = txdata_reg;
                            bit_cnt_next   = 3'd0;
                            byte_done_next = 1'b0;
                        end else begin
                            nack_set   = 1'b1;
                            state_next = IGNORE;
                        end
                    end
                end
                default: begin
                    state_next  = IDLE;
                    sda_oe_next = 1'b0;
                end
            endcase
        end
    end

    assign busy    = (state_reg != IDLE);
    assign wr_en   = psel & pwrite & penable;
    assign rd_en   = psel & ~pwrite & penable;
    assign reg_sel = paddr[3:2];

    always_comb begin
        rd_mux = 32'd0;
        case (reg_sel)
            2'b00: rd_mux = {24'd0, own_addr_reg, en_reg};
            2'b01: rd_mux = {24'd0, rxdata_reg};
            2'b10: rd_mux = {24'd0, txdata_reg};
            2'b11: rd_mux = {26'd0, underrun_reg, nack_reg, rw_reg, busy, overrun_reg, rx_valid_reg};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            prdata <= 32'd0;
            pready <= 1'b0;
        end else begin
            pready <= psel & penable;
            if (rd_en)
                prdata <= rd_mux;
        end
    end

    // Clears are applied before sets so that a bus event in the same cycle wins.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            en_reg       <= 1'b0;
            own_addr_reg <= RST_OWN_ADDR;
            rxdata_reg   <= 8'd0;
            txdata_reg   <= 8'd0;
            rx_valid_reg <= 1'b0;
            overrun_reg  <= 1'b0;
            rw_reg       <= 1'b0;
            nack_reg     <= 1'b0;
            underrun_reg <= 1'b0;
            tx_valid_reg <= 1'b0;
        end else begin
            if (wr_en && reg_sel == 2'b00) begin
                en_reg       <= pwdata[0];
                own_addr_reg <= pwdata[7:1];
            end
            if (wr_en && reg_sel == 2'b11) begin
                if (pwdata[1]) overrun_reg  <= 1'b0;
                if (pwdata[4]) nack_reg     <= 1'b0;
                if (pwdata[5]) underrun_reg <= 1'b0;
            end
            if (rd_en && reg_sel == 2'b01)
                rx_valid_reg <= 1'b0;
            if (rx_commit) begin
                rxdata_reg   <= shreg_next;
                rx_valid_reg <= 1'b1;
            end
            if (rx_overrun_set)
                overrun_reg <= 1'b1;
            if (rw_load)
                rw_reg <= sda_s;
            if (nack_set)
                nack_reg <= 1'b1;
            if (tx_load) begin
                tx_valid_reg <= 1'b0;
                if (!tx_valid_reg)
                    underrun_reg <= 1'b1;
            end
            if (wr_en && reg_sel == 2'b10) begin
                txdata_reg   <= pwdata[7:0];
                tx_valid_reg <= 1'b1;
            end
        end
    end

    logic unused_apb_bits;
    assign unused_apb_bits = &{1'b0, pwdata[31:8], paddr[1:0]};

endmodule

// File: tb/tb_i2c_slave_apb.sv
// Directed bench for i2c_slave_apb: bit-banged I2C master, APB driver and a
// transaction-level model of the register/ACK behaviour.
module tb_i2c_slave_apb;
    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic [3:0]  paddr = 4'd0;
    logic        pwrite = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [31:0] pwdata = 32'd0;
    wire  [31:0] prdata;
    wire         pready;
    logic        scl = 1'b1;
    wire         sda;
    logic        m_sda_oe = 1'b0;

    assign sda = m_sda_oe ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_apb #(.SYNC_STAGES(2), .RST_OWN_ADDR(7'h50)) dut (
        .pclk(pclk), .preset(preset), .paddr(paddr), .pwrite(pwrite),
        .psel(psel), .penable(penable), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .SCL(scl), .SDA(sda)
    );

    always #5 pclk = ~pclk;

    localparam logic [3:0] A_CTRL = 4'h0, A_RXD = 4'h4, A_TXD = 4'h8, A_STAT = 4'hC;

    typedef struct { string name; logic [31:0] act; logic [31:0] exp; } chk_t;
    chk_t chk_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic win = 1'b0;
    logic exp_low = 1'b0;

    // Transaction-level model of the target.
    logic       m_en = 1'b0, m_rx_valid = 1'b0, m_overrun = 1'b0, m_tx_valid = 1'b0;
    logic       m_underrun = 1'b0, m_nack = 1'b0, m_rw = 1'b0, m_busy = 1'b0, m_sel = 1'b0;
    logic [6:0] m_own = 7'h50;
    logic [7:0] m_rxdata = 8'd0, m_txdata = 8'd0;

    function automatic logic [31:0] m_status();
        return {26'd0, m_underrun, m_nack, m_rw, m_busy, m_overrun, m_rx_valid};
    endfunction

    // Single compare process: SDA slot checks every cycle plus queued register checks.
    always @(negedge pclk) begin : compare
        chk_t c;
        if (win && !m_sda_oe) begin
            n_checks++;
            if ((sda == 1'b0) != exp_low) begin
                n_errors++;
                $display("FAIL sda_slot t=%0t slave_low=%0b required_low=%0b", $time, ~sda, exp_low);
            end
        end
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_checks++;
            if (c.act !== c.exp) begin
                n_errors++;
                $display("FAIL %s got=0x%08h want=0x%08h", c.name, c.act, c.exp);
            end else begin
                $display("ok   %s = 0x%08h", c.name, c.act);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        chk_q.push_back('{n, a, e});
    endtask

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        cyc(1);
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        cyc(1);
        penable = 1'b1;
        cyc(1);
        chk("pready_wr", {31'd0, pready}, 32'd1);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        case (a[3:2])
            2'b00: begin m_en = d[0]; m_own = d[7:1]; end
            2'b10: begin m_txdata = d[7:0]; m_tx_valid = 1'b1; end
            2'b11: begin
                if (d[1]) m_overrun = 1'b0;
                if (d[4]) m_nack = 1'b0;
                if (d[5]) m_underrun = 1'b0;
            end
            default: ;
        endcase
        cyc(1);
    endtask

    task automatic apb_check(input string n, input logic [3:0] a, input logic [31:0] e);
        cyc(1);
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        cyc(1);
        penable = 1'b1;
        cyc(1);
        chk("pready_rd", {31'd0, pready}, 32'd1);
        chk(n, prdata, e);
        psel = 1'b0; penable = 1'b0;
        if (a[3:2] == 2'b01) m_rx_valid = 1'b0;
        cyc(1);
        chk("pready_idle", {31'd0, pready}, 32'd0);
    endtask

    // One SCL period starting and ending with SCL low.
    task automatic bit_slot(input logic drive_low, input logic expect_low, output logic s);
        m_sda_oe = drive_low;
        cyc(7);
        scl = 1'b1;
        cyc(4);
        exp_low = expect_low;
        win = 1'b1;
        cyc(5);
        s = (sda == 1'b0) ? 1'b0 : 1'b1;
        win = 1'b0;
        scl = 1'b0;
        cyc(1);
    endtask

    task automatic bus_start();
        m_sda_oe = 1'b0;
        cyc(3);
        scl = 1'b1;
        cyc(6);
        m_sda_oe = 1'b1;
        cyc(6);
        scl = 1'b0;
        cyc(1);
        m_sel = 1'b0;
        if (m_en) m_busy = 1'b1;
    endtask

    task automatic bus_stop();
        m_sda_oe = 1'b1;
        cyc(4);
        scl = 1'b1;
        cyc(6);
        m_sda_oe = 1'b0;
        cyc(8);
        m_busy = 1'b0;
        m_sel = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_slot(~b[i], 1'b0, s);
        bit_slot(1'b0, exp_ack, s);
        chk("ack_slot", {31'd0, ~s}, {31'd0, exp_ack});
    endtask

    task automatic send_addr(input logic [7:0] b);
        logic hit;
        hit = m_en && (b[7:1] == m_own);
        write_byte(b, hit);
        m_sel = hit;
        if (hit) m_rw = b[0];
    endtask

    task automatic send_data(input logic [7:0] b);
        logic wr;
        wr = m_sel && !m_rw;
        write_byte(b, wr && !m_rx_valid);
        if (wr) begin
            if (!m_rx_valid) begin m_rxdata = b; m_rx_valid = 1'b1; end
            else m_overrun = 1'b1;
        end
    endtask

    task automatic recv_data(input logic ack);
        logic [7:0] eb, got;
        logic s;
        eb = m_txdata;
        if (!m_tx_valid) m_underrun = 1'b1;
        m_tx_valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            bit_slot(1'b0, ~eb[i], s);
            got[i] = s;
        end
        chk("tx_byte", {24'd0, got}, {24'd0, eb});
        bit_slot(ack, 1'b0, s);
        if (!ack) begin m_nack = 1'b1; m_sel = 1'b0; end
    endtask

    initial begin : main
        logic s;
        cyc(3);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pready", {31'd0, pready}, 32'd0);
        chk("rst_sda", {31'd0, sda}, 32'd1);
        preset = 1'b0;
        cyc(2);
        apb_check("ctrl_rst", A_CTRL, 32'h0000_00A0);
        apb_check("status_rst", A_STAT, m_status());

        // Master write of one byte.
        apb_write(A_CTRL, 32'h0000_00A1);
        bus_start();
        send_addr(8'hA0);
        send_data(8'h3C);
        bus_stop();
        apb_check("status_rx", A_STAT, 32'h0000_0001);
        apb_check("rxdata", A_RXD, 32'h0000_003C);
        apb_check("status_after_rd", A_STAT, 32'h0000_0000);

        // Overrun: second byte arrives while RXDATA is still unread.
        bus_start();
        send_addr(8'hA0);
        send_data(8'h11);
        send_data(8'h22);
        bus_stop();
        apb_check("status_ovr", A_STAT, 32'h0000_0003);
        apb_check("rxdata_kept", A_RXD, 32'h0000_0011);
        apb_write(A_STAT, 32'h0000_0002);
        apb_check("status_ovr_clr", A_STAT, 32'h0000_0000);

        // Master read: second byte is an underrun repeat, then NACK.
        apb_write(A_TXD, 32'h0000_00A5);
        bus_start();
        send_addr(8'hA1);
        recv_data(1'b1);
        recv_data(1'b0);
        apb_check("status_ignore", A_STAT, 32'h0000_003C);
        bus_stop();
        apb_check("status_tx", A_STAT, 32'h0000_0038);
        apb_write(A_STAT, 32'h0000_0030);
        apb_check("status_tx_clr", A_STAT, m_status());

        // Foreign address: no ACK anywhere in the frame.
        bus_start();
        send_addr(8'h84);
        send_data(8'h5A);
        apb_check("status_foreign", A_STAT, m_status());
        bus_stop();
        apb_check("status_foreign_end", A_STAT, m_status());

        // Repeated START after three data bits, then a read.
        bus_start();
        send_addr(8'hA0);
        bit_slot(1'b0, 1'b0, s);
        bit_slot(1'b1, 1'b0, s);
        bit_slot(1'b0, 1'b0, s);
        bus_start();
        send_addr(8'hA1);
        recv_data(1'b0);
        bus_stop();
        apb_check("rxdata_no_partial", A_RXD, 32'h0000_0011);
        apb_check("status_rstart", A_STAT, m_status());

        // Reset while the target is actively pulling SDA low.
        apb_write(A_TXD, 32'h0000_00A5);
        bus_start();
        send_addr(8'hA1);
        bit_slot(1'b0, 1'b0, s);
        cyc(5);
        chk("sda_tx_bit6", {31'd0, sda}, 32'd0);
        preset = 1'b1;
        #1;
        chk("sda_async_release", {31'd0, sda}, 32'd1);
        chk("prdata_async_clr", prdata, 32'd0);
        cyc(2);
        scl = 1'b1;
        cyc(2);
        preset = 1'b0;
        m_en = 1'b0; m_own = 7'h50; m_rx_valid = 1'b0; m_overrun = 1'b0; m_tx_valid = 1'b0;
        m_underrun = 1'b0; m_nack = 1'b0; m_rw = 1'b0; m_busy = 1'b0; m_sel = 1'b0;
        m_rxdata = 8'd0; m_txdata = 8'd0;
        cyc(3);
        apb_check("ctrl_after_rst", A_CTRL, 32'h0000_00A0);
        apb_check("status_after_rst", A_STAT, m_status());
        apb_check("txdata_after_rst", A_TXD, 32'h0000_0000);

        cyc(4);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
